// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package serial_adder_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/HA.sv
// Single-bit half adder.
// Two of these form the bit-slice full adder of serial_adder.
module HA (
   input  logic a_i,
   input  logic b_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one result bit per clock, LSB first.
// Sum/Cout are registered and only update on the completion edge.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic s1, c1, c2;
   logic fa_s, fa_c;
   logic [WIDTH-1:0] res_sh;

   HA u_ha0 (
      .a_i (a_q[0]),
      .b_i (b_q[0]),
      .s_o (s1),
      .c_o (c1)
   );

   HA u_ha1 (
      .a_i (s1),
      .b_i (carry_q),
      .s_o (fa_s),
      .c_o (c2)
   );

   assign fa_c   = c1 | c2;
   assign res_sh = {fa_s, res_q[WIDTH-1:1]};

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (Start) begin
               a_d     = A;
               b_d     = B;
               carry_d = Cin;
               cnt_d   = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = res_sh;
            carry_d = fa_c;
            // Counter holds at the last bit so it never wraps.
            if (cnt_q == LAST) begin
               sum_d   = res_sh;
               cout_d  = fa_c;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign Busy = (state_q == ADD);
   assign Done = (state_q == DONE);
   assign Sum  = sum_q;
   assign Cout = cout_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The parameter list SHALL be: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The port list SHALL be, in order:
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous active-high reset
- Start  input  1  request to begin an addition, sampled only in IDLE
- A  input  WIDTH  operand A, captured on the accepted Start edge
- B  input  WIDTH  operand B, captured on the accepted Start edge
- Cin  input  1  carry-in, captured on the accepted Start edge
- Busy  output  1  high while an addition is in progress (state ADD)
- Done  output  1  one-cycle pulse marking Sum/Cout valid
- Sum  output  WIDTH  registered result A+B+Cin mod 2^WIDTH
- Cout  output  1  registered carry-out of the WIDTH-bit sum

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-005 In IDLE with Start=1 at a rising edge, the block SHALL load A and B into shift registers, load Cin into the carry flop, clear the bit counter and enter ADD.
REQ-006 Each clock edge in ADD SHALL process exactly one bit, LSB first: it computes the full-adder sum and carry of the A LSB, B LSB and carry flop, shifts the sum bit into the result shift register from the MSB end, shifts A and B right by one, updates the carry flop and increments the counter.
REQ-007 The edge that processes bit WIDTH-1 SHALL copy the result register to Sum and the final carry to Cout, and SHALL enter DONE.
REQ-008 DONE SHALL last exactly one cycle and then return unconditionally to IDLE.
REQ-009 Latency: when Start is accepted at edge k, Done SHALL be high only during the cycle between edges k+WIDTH and k+WIDTH+1.
REQ-010 Busy SHALL be high only in ADD, and Done SHALL be high only in DONE; both are decoded Moore outputs.
REQ-011 Sum and Cout SHALL hold their last values from DONE through IDLE until the next completion or reset.
REQ-012 Sum and Cout SHALL change only on the completion edge (REQ-007); partial results SHALL never appear on them.
REQ-013 Start SHALL be ignored in ADD and DONE, and changes to A, B or Cin after the accepted edge SHALL have no effect.
REQ-014 A new Start in the first IDLE cycle after DONE SHALL be accepted, so back-to-back operations complete every WIDTH+2 cycles.
REQ-015 The counter SHALL be wide enough to hold WIDTH-1 and SHALL not wrap during an operation.

Reset
REQ-016 RST=1 at any edge SHALL force state IDLE and clear Busy, Done, Sum, Cout, the carry flop, the counter and all shift registers to 0.
REQ-017 RST SHALL take priority over Start and over any in-progress ADD, and an aborted operation SHALL never produce Done.

Structure
REQ-018 A package serial_adder_pkg SHALL hold the state enum (IDLE, ADD, DONE) and the default WIDTH constant.
REQ-019 The bit-slice full adder SHALL be built from two instances of the existing half-adder module HA, with carry = Cout1 | Cout2, and no other sub-modules are permitted.

Verification
REQ-020 The bench SHALL cover these directed scenarios, with WIDTH=8:
- A=0x3C, B=0x0F, Cin=0, Start at edge k -> Busy for 8 cycles; Done pulses in cycle k+8; Sum=0x4B, Cout=0.
- A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1.
- A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Cout=1.
- Start re-asserted during ADD with different A/B -> ignored; the first result is unchanged; exactly one Done.
- RST during ADD after 4 bits -> next cycle IDLE; Busy=0, Sum=0x00, Cout=0; no Done.
- Two back-to-back operations, 0x01+0x02 then 0x80+0x80 -> Done at k+8 and k+18; Sum=0x03 then 0x00 with Cout=1.
